burst_memory: RTL and testbench
===============================

# burst_memory

Parametrised single-port synchronous memory with a valid/ready command handshake and multi-beat bursts. A single command accepts a start address and a burst length and moves 1 to MAX_BURST consecutive words. Address overrun is handled by a selectable mode: wrap around the array, or reject the command with an error flag. It replaces the single-beat memory as the processor-facing storage block. The array is named `mem` so benches can load and dump it by hierarchical access.

## Interface
- WIDTH, 8, data word width in bits
- DEPTH, 32, number of words; any value ≥ 2
- ADDR_WIDTH, $clog2(DEPTH), address width
- MAX_BURST, 8, maximum beats per command; power of 2
- BURST_WIDTH, $clog2(MAX_BURST), width of burst_len
- WRAP, 1, 1 = addresses wrap modulo DEPTH; 0 = overrunning commands are rejected

Ports:
- clk  in  1  clock; everything is updated on the rising edge
- rst  in  1  reset, synchronous, active-high
- valid  in  1  command or write beat present
- ready  out  1  block can accept a command or write beat
- wr_rd  in  1  1 = write, 0 = read; sampled with the command
- addr  in  ADDR_WIDTH  start address; sampled with the command
- burst_len  in  BURST_WIDTH  beats minus 1; sampled with the command
- wdata  in  WIDTH  write data for the current beat
- rdata  out  WIDTH  read data
- rvalid  out  1  rdata holds a valid beat this cycle
- error  out  1  one-cycle pulse: command rejected

## Operation
- States: IDLE, WRITE, READ.
- Command acceptance: a command is accepted when the block is in IDLE and valid && ready. The block latches wr_rd, a current-address register (cur = addr), and a beat counter (cnt = burst_len).
- Overrun check, WRAP=0: the check is done in ADDR_WIDTH+1 bits. If addr + burst_len > DEPTH-1:
  - error = 1 for the next cycle;
  - there is no memory access;
  - the state stays IDLE.
- Overrun check, WRAP=1: there is no check. The next address is 0 when cur == DEPTH-1, otherwise cur+1. This also holds for DEPTH that is not a power of 2.
- Write commands:
  - The command cycle also carries beat 0, so mem[addr] = wdata at the acceptance edge.
  - If burst_len == 0, the state stays IDLE. Otherwise the state goes to WRITE.
- WRITE state:
  - ready = 1.
  - Each valid && ready cycle writes wdata to mem[cur], advances cur and decrements cnt.
  - valid = 0 stalls the burst indefinitely; nothing is written.
  - The final beat (cnt == 1 before decrement) returns the state to IDLE.
- Read commands: the state goes to READ.
- READ state:
  - ready = 0.
  - Every cycle: rdata = mem[cur], rvalid = 1, cur advances, cnt decrements.
  - After burst_len+1 beats the state returns to IDLE.
  - Reads cannot be stalled.
- rdata holds its last value while rvalid = 0.
- The memory is updated before any later read, so read-after-write with back-to-back commands returns the new data.
- Reset (any state, including mid-burst):
  - state = IDLE, ready = 1, rvalid = 0, error = 0, rdata = 0, cur = 0, cnt = 0;
  - all mem locations are cleared to 0;
  - any burst in progress is abandoned.
- ready in IDLE is 1 regardless of valid.

## Timing
- Command accepted at edge T.
- Write: beat 0 is in mem after T. Beat k is written at the k-th later handshake edge.
- Read:
  - beat k is registered at edge T+1+k, for k = 0..burst_len;
  - rvalid is high for burst_len+1 consecutive cycles starting after T+1;
  - the state is IDLE after edge T+1+burst_len, so the earliest next command is accepted at T+2+burst_len.
- Single-beat read latency: 1 cycle after acceptance.
- error is high for exactly the cycle after the rejecting edge. The next command can be accepted in that same cycle.
- Max burst is burst_len = MAX_BURST-1, which gives MAX_BURST beats.

## Test plan
- **Single-beat write/read.** After reset, write addr 15 = 8'hA5 with burst_len=0, then read addr 15 with burst_len=0 → rvalid for 1 cycle, rdata = 8'hA5, exactly 1 cycle after the read is accepted.
- **Full burst.** Write burst at addr 16, burst_len=7, data 8'h10..8'h17, then read burst at addr 16, burst_len=7 → 8 consecutive rvalid cycles with rdata 8'h10..8'h17; ready low throughout the read.
- **Stalled write.** Write burst at addr 0, burst_len=3, with valid dropped for 3 cycles between beats 1 and 2 → mem[0..3] hold the 4 supplied words; no extra writes occur during the stall.
- **Wrap mode.** With WRAP=1, DEPTH=32: write burst at addr 30, burst_len=3 → data lands in mem[30], mem[31], mem[0], mem[1]; a read burst from addr 30 returns the same order.
- **Reject mode.** With WRAP=0: a command at addr 30 with burst_len=3 → error pulses for 1 cycle, mem is unchanged, no rvalid; a following read at addr 30 with burst_len=1 succeeds.
- **Reset mid-burst.** Assert rst during the 3rd beat of a read burst → the next cycle has rvalid=0, ready=1; a subsequent read of any address returns 0.

Source files
------------

// File: rtl/burst_memory.sv
// Single-port synchronous memory with a valid/ready command handshake and multi-beat bursts.
// Overrun handling is chosen at elaboration time: wrap modulo DEPTH, or reject with an error pulse.
module burst_memory #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 32,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int MAX_BURST   = 8,
    parameter int BURST_WIDTH = $clog2(MAX_BURST),
    parameter int WRAP        = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid,
    output logic                   ready,
    input  logic                   wr_rd,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [BURST_WIDTH-1:0] burst_len,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   rvalid,
    output logic                   error
);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    logic [WIDTH-1:0] mem [DEPTH];

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH-1:0]  cur;
    logic [BURST_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH:0]    end_addr;
    logic                   overrun, accept, reject, do_wr;
    logic [ADDR_WIDTH-1:0]  wr_addr;

    // Explicit compare keeps wrapping correct for non-power-of-2 DEPTH.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        if (a == ADDR_WIDTH'(DEPTH - 1))
            return '0;
        return a + ADDR_WIDTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = (state != READ);
        accept    = 1'b0;
        reject    = 1'b0;
        do_wr     = 1'b0;
        wr_addr   = cur;
        end_addr  = {1'b0, addr} + (ADDR_WIDTH + 1)'(burst_len);
        overrun   = (WRAP == 0) && (end_addr > (ADDR_WIDTH + 1)'(DEPTH - 1));
        case (state)
            IDLE: begin
                if (valid && overrun) begin
                    reject = 1'b1;
                end else if (valid) begin
                    accept = 1'b1;
                    if (wr_rd) begin
                        // The command cycle carries write beat 0.
                        do_wr   = 1'b1;
                        wr_addr = addr;
                        if (burst_len != '0)
                            state_nxt = WRITE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            WRITE: begin
                if (valid) begin
                    do_wr = 1'b1;
                    if (cnt == BURST_WIDTH'(1))
                        state_nxt = IDLE;
                end
            end
            READ: begin
                if (cnt == '0)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (do_wr) begin
            mem[wr_addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur    <= '0;
            cnt    <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
            error  <= 1'b0;
        end else begin
            error  <= reject;
            rvalid <= (state == READ);
            if (state == READ)
                rdata <= mem[cur];
            // Writes already consumed beat 0, so they start one address ahead.
            if (accept) begin
                cur <= wr_rd ? next_addr(addr) : addr;
                cnt <= burst_len;
            end else if (do_wr || state == READ) begin
                cur <= next_addr(cur);
                cnt <= cnt - BURST_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_burst_memory.sv
// Scoreboard bench for burst_memory: one WRAP=1 instance for the main plan, one WRAP=0 for rejection.
module tb_burst_memory;

    logic clk = 1'b0;
    logic rst;
    logic [1:0]      valid, wr_rd, ready, rvalid, error;
    logic [1:0][4:0] addr;
    logic [1:0][2:0] blen;
    logic [1:0][7:0] wdata, rdata;

    int total = 0;
    int bad   = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    burst_memory #(.WIDTH(8), .DEPTH(32), .MAX_BURST(8), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .valid(valid[0]), .ready(ready[0]), .wr_rd(wr_rd[0]),
        .addr(addr[0]), .burst_len(blen[0]), .wdata(wdata[0]), .rdata(rdata[0]),
        .rvalid(rvalid[0]), .error(error[0])
    );

    burst_memory #(.WIDTH(8), .DEPTH(32), .MAX_BURST(8), .WRAP(0)) u_rej (
        .clk(clk), .rst(rst), .valid(valid[1]), .ready(ready[1]), .wr_rd(wr_rd[1]),
        .addr(addr[1]), .burst_len(blen[1]), .wdata(wdata[1]), .rdata(rdata[1]),
        .rvalid(rvalid[1]), .error(error[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int d, input logic [7:0] v);
        if (d == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    // Monitor: every presented read beat must match the next queued expectation.
    always @(negedge clk) begin
        if (rvalid[0] === 1'b1) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL rd0_unexpected: got beat %0h with nothing expected at %0t", rdata[0], $time);
            end else begin
                logic [7:0] e0;
                e0 = q0.pop_front();
                if (rdata[0] !== e0) begin
                    bad++;
                    $display("FAIL rd0_data: got %0h expected %0h at %0t", rdata[0], e0, $time);
                end
            end
        end
        if (rvalid[1] === 1'b1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL rd1_unexpected: got beat %0h with nothing expected at %0t", rdata[1], $time);
            end else begin
                logic [7:0] e1;
                e1 = q1.pop_front();
                if (rdata[1] !== e1) begin
                    bad++;
                    $display("FAIL rd1_data: got %0h expected %0h at %0t", rdata[1], e1, $time);
                end
            end
        end
    end

    task automatic send(input int d, input bit wr, input int a, input int bl, input logic [7:0] wd);
        @(negedge clk);
        chk("cmd_ready", ready[d], 1);
        valid[d] = 1'b1;
        wr_rd[d] = wr;
        addr[d]  = a[4:0];
        blen[d]  = bl[2:0];
        wdata[d] = wd;
        @(posedge clk);
        #1 valid[d] = 1'b0;
    endtask

    task automatic beat(input int d, input logic [7:0] wd);
        @(negedge clk);
        chk("wr_ready", ready[d], 1);
        valid[d] = 1'b1;
        wdata[d] = wd;
        @(posedge clk);
        #1 valid[d] = 1'b0;
    endtask

    // Read burst: rvalid must appear one cycle after acceptance and stay up for bl+1 cycles.
    task automatic rd(input int d, input int a, input int bl);
        send(d, 1'b0, a, bl, 8'h00);
        for (int k = 0; k <= bl; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rd_valid", rvalid[d], 1);
            chk("rd_ready", ready[d], (k < bl) ? 0 : 1);
        end
        @(posedge clk);
        @(negedge clk);
        chk("rd_end", rvalid[d], 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        valid = '0; wr_rd = '0; addr = '0; blen = '0; wdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready, 2'b11);
        chk("rst_rvalid", rvalid, 2'b00);
        chk("rst_error", error, 2'b00);
        chk("rst_rdata", rdata, 16'h0000);
        rst = 1'b0;

        // Single-beat write then read
        send(0, 1'b1, 15, 0, 8'hA5);
        chk("mem15", u_wrap.mem[15], 8'hA5);
        push_exp(0, 8'hA5);
        rd(0, 15, 0);

        // Full 8-beat burst
        send(0, 1'b1, 16, 7, 8'h10);
        for (int k = 1; k < 8; k++) beat(0, 8'(8'h10 + k));
        for (int k = 0; k < 8; k++) push_exp(0, 8'(8'h10 + k));
        rd(0, 16, 7);

        // Wrap around the top of the array
        send(0, 1'b1, 30, 3, 8'hC0);
        beat(0, 8'hC1); beat(0, 8'hC2); beat(0, 8'hC3);
        chk("wrap_mem30", u_wrap.mem[30], 8'hC0);
        chk("wrap_mem31", u_wrap.mem[31], 8'hC1);
        chk("wrap_mem0",  u_wrap.mem[0],  8'hC2);
        chk("wrap_mem1",  u_wrap.mem[1],  8'hC3);
        push_exp(0, 8'hC0); push_exp(0, 8'hC1); push_exp(0, 8'hC2); push_exp(0, 8'hC3);
        rd(0, 30, 3);

        // Stalled write: valid low for 3 cycles with junk on wdata
        send(0, 1'b1, 0, 3, 8'h50);
        beat(0, 8'h51);
        @(negedge clk);
        wdata[0] = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_mem2", u_wrap.mem[2], 8'h00);
        chk("stall_mem3", u_wrap.mem[3], 8'h00);
        beat(0, 8'h52); beat(0, 8'h53);
        chk("stall_mem0", u_wrap.mem[0], 8'h50);
        chk("stall_mem1", u_wrap.mem[1], 8'h51);
        chk("stall_mem2b", u_wrap.mem[2], 8'h52);
        chk("stall_mem3b", u_wrap.mem[3], 8'h53);
        chk("stall_mem4", u_wrap.mem[4], 8'h00);

        // Reject mode: preload, overrunning command, then legal read in the error cycle
        send(1, 1'b1, 30, 1, 8'h3A);
        beat(1, 8'h3B);
        chk("rej_pre30", u_rej.mem[30], 8'h3A);
        chk("rej_pre31", u_rej.mem[31], 8'h3B);
        send(1, 1'b1, 30, 3, 8'hEE);
        fork
            begin
                @(negedge clk);
                chk("rej_error_hi", error[1], 1);
                @(negedge clk);
                chk("rej_error_lo", error[1], 0);
            end
        join_none
        push_exp(1, 8'h3A); push_exp(1, 8'h3B);
        rd(1, 30, 1);
        chk("rej_mem30", u_rej.mem[30], 8'h3A);
        chk("rej_mem0", u_rej.mem[0], 8'h00);
        chk("rej_mem1", u_rej.mem[1], 8'h00);

        // Reset during the 3rd beat of a read burst
        push_exp(0, 8'h10); push_exp(0, 8'h11);
        send(0, 1'b0, 16, 7, 8'h00);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_rvalid", rvalid[0], 0);
        chk("mid_rst_ready", ready[0], 1);
        chk("mid_rst_rdata", rdata[0], 8'h00);
        rst = 1'b0;
        push_exp(0, 8'h00); push_exp(0, 8'h00);
        rd(0, 16, 1);
        chk("mid_rst_mem31", u_wrap.mem[31], 8'h00);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
